// File: rtl/score_vector_packer_if.sv
// Class-score bus bundle: accumulator stream in, packed score vector out.
// Carries the acc valid/ready stream, the frame abort and the vector valid/ready handshake.
// The master modport is the producer/consumer environment; the slave modport is the packer.
interface score_vector_packer_if #(
  parameter int NUM_CLASSES = 10,
  parameter int ACC_W       = 20,
  parameter int OUT_W       = 8
);
  logic [ACC_W-1:0]             acc_in;
  logic                         acc_valid;
  logic                         acc_ready;
  logic                         abort;
  logic [NUM_CLASSES*OUT_W-1:0] scores_out;
  logic                         vec_valid;
  logic                         vec_ready;
  logic                         sat_flag;

  modport master (
    output acc_in, acc_valid, abort, vec_ready,
    input  acc_ready, scores_out, vec_valid, sat_flag
  );

  modport slave (
    input  acc_in, acc_valid, abort, vec_ready,
    output acc_ready, scores_out, vec_valid, sat_flag
  );
endinterface

// File: rtl/score_vector_packer.sv
// Purpose: requantizes NUM_CLASSES signed accumulators to 8-bit scores and presents them as one vector.
// Latency: 1 clk from the last accumulator accept to vec_valid.
// Backpressure: acc_ready is held low while a vector waits for vec_ready (and in the handshake cycle).
// Ports: clk, rst_n (async, active low); bus.slave carries acc_in/acc_valid/acc_ready, abort,
//   scores_out (lane k at [k*OUT_W +: OUT_W]), vec_valid/vec_ready and sat_flag.
module score_vector_packer #(
  parameter int NUM_CLASSES = 10,
  parameter int ACC_W       = 20,
  parameter int OUT_W       = 8,
  parameter int SHIFT       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  score_vector_packer_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [ACC_W-1:0] MAX_Q = ACC_W'((1 << OUT_W) - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                       state, state_nxt;
  logic [IDX_W-1:0]             idx;
  logic [NUM_CLASSES*OUT_W-1:0] scores_q;
  logic                         sat_q;
  logic                         acc_rdy, vec_vld, accept;

  logic signed [ACC_W-1:0]      q;
  logic [OUT_W-1:0]             req_lane;
  logic                         req_sat;

  // Requantize: arithmetic shift, negative results clamp to zero (ReLU, not
  // saturation), results above the lane range saturate and raise the flag.
  always_comb begin
    q        = $signed(bus.acc_in) >>> SHIFT;
    req_lane = '0;
    req_sat  = 1'b0;
    if (q < 0) begin
      req_lane = '0;
    end else if (q > MAX_Q) begin
      req_lane = '1;
      req_sat  = 1'b1;
    end else begin
      req_lane = q[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_rdy   = (state == COLLECT);
    vec_vld   = (state == HOLD);
    // Abort wins over everything, including an accept in the same cycle.
    accept    = acc_rdy && bus.acc_valid && !bus.abort;
    if (bus.abort) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (accept && idx == LAST_IDX) state_nxt = HOLD;
        HOLD:    if (bus.vec_ready)             state_nxt = COLLECT;
        default:                                state_nxt = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      scores_q <= '0;
      sat_q    <= 1'b0;
    end else if (bus.abort) begin
      // Lanes keep stale data; nothing exposes them until a full new frame lands.
      idx   <= '0;
      sat_q <= 1'b0;
    end else if (accept) begin
      scores_q[idx*OUT_W +: OUT_W] <= req_lane;
      idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      // The previous vector's flag stays visible until the next frame's first accept.
      sat_q <= (idx == '0) ? req_sat : (sat_q | req_sat);
    end
  end

  assign bus.acc_ready  = acc_rdy;
  assign bus.vec_valid  = vec_vld;
  assign bus.scores_out = scores_q;
  assign bus.sat_flag   = sat_q;
endmodule

// File: tb/tb_score_vector_packer.sv
// Self-checking bench for score_vector_packer with a floor-division requant reference model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that same point.
// Every comparison is an immediate assertion that counts failures toward the summary line.
module tb_score_vector_packer;
  localparam int NC = 10;
  localparam int AW = 20;
  localparam int OW = 8;
  localparam int VW = NC * OW;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  score_vector_packer_if #(.NUM_CLASSES(NC), .ACC_W(AW), .OUT_W(OW)) bus ();

  score_vector_packer #(.NUM_CLASSES(NC), .ACC_W(AW), .OUT_W(OW), .SHIFT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] frame_vals [NC];
  logic          prev_sat;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: floor(a / 256), then ReLU and clamp to 255.
  function automatic int ref_q(input logic [AW-1:0] v);
    int a;
    a = $signed(v);
    if (a >= 0) return a / 256;
    return -((-a + 255) / 256);
  endfunction

  function automatic logic [OW-1:0] ref_lane(input logic [AW-1:0] v);
    int q;
    q = ref_q(v);
    if (q < 0)   return 8'd0;
    if (q > 255) return 8'd255;
    return OW'(q);
  endfunction

  function automatic logic ref_sat(input logic [AW-1:0] v);
    return ref_q(v) > 255;
  endfunction

  function automatic logic [AW-1:0] rand_acc();
    case ($urandom_range(0, 3))
      0:       return AW'($urandom);
      1:       return AW'($urandom_range(0, 66000));
      2:       return AW'(-$urandom_range(1, 2000));
      default: return AW'($urandom_range(0, 255) * 256);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one value and hold it until the packer takes it (bounded).
  task automatic send(input logic [AW-1:0] v);
    int n;
    n = 0;
    bus.acc_in    = v;
    bus.acc_valid = 1'b1;
    while (!bus.acc_ready && n < 200) begin
      tick();
      n++;
    end
    check("send_timeout", VW'(n >= 200), VW'(0));
    tick();
    bus.acc_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input string tag);
    logic [VW-1:0] exp_vec;
    logic          exp_sat;
    exp_vec = '0;
    exp_sat = 1'b0;
    check({tag, "_sat_before"}, VW'(bus.sat_flag), VW'(prev_sat));
    for (int i = 0; i < NC; i++) begin
      if (gaps) begin
        for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) tick();
      end
      check({tag, "_no_early_valid"}, VW'(bus.vec_valid), VW'(0));
      send(frame_vals[i]);
      exp_vec[i*OW +: OW] = ref_lane(frame_vals[i]);
      exp_sat = exp_sat | ref_sat(frame_vals[i]);
      if (i == 0) check({tag, "_sat_first"}, VW'(bus.sat_flag), VW'(ref_sat(frame_vals[0])));
    end
    check({tag, "_vec_valid"}, VW'(bus.vec_valid), VW'(1));
    check({tag, "_acc_ready"}, VW'(bus.acc_ready), VW'(0));
    check({tag, "_scores"},    bus.scores_out,     exp_vec);
    check({tag, "_sat"},       VW'(bus.sat_flag),  VW'(exp_sat));
    prev_sat = exp_sat;
  endtask

  task automatic handshake(input string tag);
    bus.vec_ready = 1'b1;
    tick();
    bus.vec_ready = 1'b0;
    check({tag, "_hs_valid"}, VW'(bus.vec_valid), VW'(0));
    check({tag, "_hs_ready"}, VW'(bus.acc_ready), VW'(1));
    check({tag, "_hs_sat"},   VW'(bus.sat_flag),  VW'(prev_sat));
  endtask

  initial begin
    logic [VW-1:0] held;
    checks = 0;
    errors = 0;
    prev_sat = 1'b0;
    bus.acc_in = '0;
    bus.acc_valid = 1'b0;
    bus.abort = 1'b0;
    bus.vec_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_vec_valid", VW'(bus.vec_valid), VW'(0));
    check("rst_sat",       VW'(bus.sat_flag),  VW'(0));
    check("rst_scores",    bus.scores_out,     '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst_acc_ready", VW'(bus.acc_ready), VW'(1));

    // 1: back-to-back k*256
    for (int k = 0; k < NC; k++) frame_vals[k] = AW'(k * 256);
    send_frame(1'b0, "t1");
    handshake("t1");

    // 2: ReLU, saturation and the 255 boundary
    frame_vals[0] = AW'(-300);
    frame_vals[1] = AW'(65536);
    frame_vals[2] = AW'(65535);
    for (int k = 3; k < NC; k++) frame_vals[k] = AW'(k * 100);
    send_frame(1'b0, "t2a");
    handshake("t2a");
    frame_vals[0] = AW'(65535);
    for (int k = 1; k < NC; k++) frame_vals[k] = AW'(-k * 37);
    send_frame(1'b0, "t2b");

    // 3: stall in HOLD with acc_valid high
    held = bus.scores_out;
    bus.acc_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.acc_in = rand_acc();
      tick();
      check("t3_valid",  VW'(bus.vec_valid), VW'(1));
      check("t3_ready",  VW'(bus.acc_ready), VW'(0));
      check("t3_scores", bus.scores_out,     held);
    end
    bus.vec_ready = 1'b1;
    tick();
    bus.vec_ready = 1'b0;
    bus.acc_valid = 1'b0;
    check("t3_hs_valid", VW'(bus.vec_valid), VW'(0));
    check("t3_hs_ready", VW'(bus.acc_ready), VW'(1));

    // 4: random values with random valid gaps
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NC; k++) frame_vals[k] = rand_acc();
      send_frame(1'b1, "t4");
      handshake("t4");
    end

    // 5: abort after 6 accepts
    send(AW'(70000));
    for (int k = 1; k < 6; k++) send(AW'(k * 512));
    check("t5_sat_pre", VW'(bus.sat_flag), VW'(1));
    bus.abort = 1'b1;
    bus.acc_valid = 1'b1;
    bus.acc_in = AW'(12345);
    tick();
    bus.abort = 1'b0;
    bus.acc_valid = 1'b0;
    check("t5_abort_valid", VW'(bus.vec_valid), VW'(0));
    check("t5_abort_sat",   VW'(bus.sat_flag),  VW'(0));
    check("t5_abort_ready", VW'(bus.acc_ready), VW'(1));
    prev_sat = 1'b0;
    for (int k = 0; k < NC; k++) frame_vals[k] = AW'((k + 20) * 256 + 17);
    send_frame(1'b0, "t5");
    handshake("t5");

    // 6: async reset mid-HOLD
    for (int k = 0; k < NC; k++) frame_vals[k] = (k == 4) ? AW'(100000) : AW'(k * 300);
    send_frame(1'b0, "t6a");
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid",  VW'(bus.vec_valid), VW'(0));
    check("t6_rst_sat",    VW'(bus.sat_flag),  VW'(0));
    check("t6_rst_scores", bus.scores_out,     '0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    prev_sat = 1'b0;
    for (int k = 0; k < NC; k++) frame_vals[k] = AW'((NC - k) * 256);
    send_frame(1'b1, "t6b");
    handshake("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
